membus_controller: RTL and testbench
====================================

Name: membus_controller

Overview:
- Parametrised, fully synchronous successor to the lab memory bus.
- Replaces the tristate shared databus with separate write-data and read-data paths.
- Owns an internal word-addressed RAM and a small control FSM with three modes:
  - MANUAL: switch address; write/read on button press.
  - SCAN: timed auto-increment readback.
  - FILL: burst-writes a ramp pattern into every word.
- Sits between the dip/button inputs and the display driver; addr_out/data_out feed the display word.

Parameters:
- DATA_W, 8, data word width in bits (1..32)
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
- SCAN_DIV, 24'd12_000_000, clock cycles per SCAN step (>=2)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- mode  input  2  00 MANUAL, 01 SCAN, 10 FILL, 11 treated as MANUAL
- addr_in  input  ADDR_W  manual address / unused in SCAN and FILL
- data_in  input  DATA_W  write data (MANUAL) or ramp seed (FILL)
- wr_btn  input  1  write request level (clean, already debounced upstream)
- rd_btn  input  1  read request level (clean, already debounced upstream)
- addr_out  output  ADDR_W  address associated with data_out
- data_out  output  DATA_W  last read or written word
- data_valid  output  1  high once data_out holds a real RAM word
- busy  output  1  high while FILL burst in progress

Behaviour:
- Clock/reset: one clock clk; reset rst is asynchronous, active-high.
- Reset values: addr_out=0, data_out=0, data_valid=0, busy=0, FSM=IDLE, scan address=0, divider=0, synchroniser flops=0.
- RAM contents are not reset.
- Input conditioning:
  - wr_btn and rd_btn pass through 2-flop synchronisers, then rising-edge detect, giving 1-cycle pulses wr_p/rd_p.
  - Total latency from pin to pulse: 3 cycles.
- mode is sampled only in IDLE; a mode change mid-FILL takes effect after FILL completes.
- FSM states:
  - IDLE/MANUAL (mode 00 or 11):
    - wr_p: RAM[addr_in] <= data_in. Next cycle: data_out=data_in, addr_out=addr_in, data_valid=1 (write-through display).
    - rd_p: registered read. Next cycle: data_out=RAM[addr_in], addr_out=addr_in, data_valid=1.
    - wr_p and rd_p in the same cycle: write wins; result identical to write alone.
  - IDLE -> SCAN when mode=01:
    - Divider counts 0..SCAN_DIV-1.
    - On terminal count, read RAM[scan_addr]; next cycle data_out/addr_out update, then scan_addr increments, wrapping DEPTH-1 -> 0.
    - Buttons are ignored.
    - Leaving mode 01 returns to IDLE and clears the divider; scan_addr is retained.
  - IDLE -> FILL on wr_p while mode=10:
    - busy=1. Writes RAM[i] = (data_in + i) mod 2**DATA_W for i=0..DEPTH-1, one word per cycle.
    - data_in is latched at entry.
    - After the last word: busy=0, addr_out=DEPTH-1, data_out=last word, data_valid=1, state -> IDLE.
    - All button pulses are ignored while busy.
    - Total busy duration: exactly DEPTH cycles.
- Arithmetic: ramp add is DATA_W wide with carry discarded; scan address wraps naturally at ADDR_W bits.
- Reset mid-FILL or mid-SCAN:
  - Immediate return to reset values.
  - RAM keeps any words already written.
  - Partial fill is not resumed.

Decomposition:
- Shared package/header `membus_pkg`:
  - mode encodings MODE_MANUAL=2'b00, MODE_SCAN=2'b01, MODE_FILL=2'b10
  - FSM state encodings S_IDLE, S_SCAN, S_FILL
- Sub-module `btn_edge`:
  - 2-flop synchroniser plus rising-edge pulse.
  - Instantiated twice (wr, rd), with clk/rst.
- The RAM is an inferred array inside membus_controller (single port, synchronous read).

Test Plan:
- Reset release, DATA_W=8, ADDR_W=4 -> all outputs 0, busy=0, data_valid=0.
- MANUAL: addr_in=4'h3, data_in=8'hA5, wr_btn rise -> 4 cycles later data_out=A5, addr_out=3, data_valid=1. Then addr_in=3, rd_btn rise -> data_out=A5.
- MANUAL, wr and rd rise on the same cycle with data_in=8'h11 at addr 5 -> data_out=11; a subsequent read of 5 returns 11.
- FILL: mode=10, data_in=8'hFE, wr rise -> busy high exactly 16 cycles, then RAM[0]=FE, RAM[1]=FF, RAM[2]=00, RAM[15]=0D; addr_out=F, data_out=0D. rd_btn pulses during busy have no effect.
- SCAN with SCAN_DIV=4 after FILL seed 8'h00 -> addr_out steps 0,1,2,… every 4 cycles with data_out==addr_out; wraps F -> 0.
- Assert rst for 1 cycle mid-FILL at i=6 -> outputs return to 0 immediately. Readback in MANUAL: RAM[0..5] hold ramp values, RAM[6..15] unchanged.

Source files
------------

// File: rtl/membus_pkg.sv
// Shared mode encodings and controller state type for the memory bus controller.
package membus_pkg;

  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_FILL   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_FILL
  } state_e;

  // Mode 11 is reserved and behaves as MANUAL.
  function automatic logic is_manual(input logic [1:0] mode);
    return (mode == MODE_MANUAL) || (mode == 2'b11);
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchroniser followed by a registered rising-edge detector;
// a pin rise appears as a one-cycle pulse three clocks later.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic sync1, sync2, sync_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
      pulse     <= 1'b0;
    end else begin
      sync1     <= btn;
      sync2     <= sync1;
      sync_prev <= sync2;
      pulse     <= sync2 & ~sync_prev;
    end
  end

endmodule

// File: rtl/membus_controller.sv
// Memory bus controller: internal word RAM with MANUAL access, timed SCAN
// readback and a ramp FILL burst, driving the display address/data word.
module membus_controller
  import membus_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 4,
  parameter logic [23:0] SCAN_DIV = 24'd12_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr_btn,
  input  logic              rd_btn,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  state_e state, state_n;

  logic              wr_p, rd_p;
  logic [23:0]       div;
  logic [ADDR_W-1:0] scan_addr;
  logic [ADDR_W-1:0] fill_idx;
  logic [DATA_W-1:0] fill_seed;
  logic [DATA_W-1:0] fill_word;

  logic              man_wr, man_rd, scan_step, fill_start, fill_last;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram [DEPTH];

  btn_edge u_wr_edge (.clk(clk), .rst(rst), .btn(wr_btn), .pulse(wr_p));
  btn_edge u_rd_edge (.clk(clk), .rst(rst), .btn(rd_btn), .pulse(rd_p));

  assign fill_word = fill_seed + DATA_W'(fill_idx);
  assign busy      = (state == S_FILL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    man_wr     = 1'b0;
    man_rd     = 1'b0;
    scan_step  = 1'b0;
    fill_start = 1'b0;
    fill_last  = 1'b0;
    case (state)
      S_IDLE: begin
        if (mode == MODE_SCAN) begin
          state_n = S_SCAN;
        end else if (mode == MODE_FILL) begin
          if (wr_p) begin
            state_n    = S_FILL;
            fill_start = 1'b1;
          end
        end else if (is_manual(mode)) begin
          man_wr = wr_p;
          man_rd = rd_p & ~wr_p;
        end
      end
      S_SCAN: begin
        if (mode != MODE_SCAN)             state_n   = S_IDLE;
        else if (div == SCAN_DIV - 24'd1)  scan_step = 1'b1;
      end
      S_FILL: begin
        if (fill_idx == '1) begin
          fill_last = 1'b1;
          state_n   = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    ram_we    = man_wr | (state == S_FILL);
    ram_waddr = (state == S_FILL) ? fill_idx : addr_in;
    ram_wdata = (state == S_FILL) ? fill_word : data_in;
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div        <= '0;
      scan_addr  <= '0;
      fill_idx   <= '0;
      fill_seed  <= '0;
      addr_out   <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      if (state == S_SCAN && mode == MODE_SCAN)
        div <= scan_step ? '0 : div + 24'd1;
      else
        div <= '0;

      if (fill_start) begin
        fill_seed <= data_in;
        fill_idx  <= '0;
      end else if (state == S_FILL) begin
        fill_idx <= fill_idx + 1'b1;
      end

      if (man_wr) begin
        addr_out   <= addr_in;
        data_out   <= data_in;
        data_valid <= 1'b1;
      end else if (man_rd) begin
        addr_out   <= addr_in;
        data_out   <= ram[addr_in];
        data_valid <= 1'b1;
      end else if (scan_step) begin
        addr_out   <= scan_addr;
        data_out   <= ram[scan_addr];
        data_valid <= 1'b1;
        scan_addr  <= scan_addr + 1'b1;
      end else if (fill_last) begin
        addr_out   <= '1;
        data_out   <= fill_word;
        data_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_membus_controller.sv
// Directed bench for membus_controller with a scoreboard queue of expected
// display words.
module tb_membus_controller;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] data_in;
  logic          wr_btn, rd_btn;
  logic [AW-1:0] addr_out;
  logic [DW-1:0] data_out;
  logic          data_valid, busy;

  always #5 clk = ~clk;

  membus_controller #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .SCAN_DIV(24'd4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .addr_in   (addr_in),
    .data_in   (data_in),
    .wr_btn    (wr_btn),
    .rd_btn    (rd_btn),
    .addr_out  (addr_out),
    .data_out  (data_out),
    .data_valid(data_valid),
    .busy      (busy)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model_ram[DEPTH];
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: observed=empty-queue expected=entry", tag);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_addr"},  32'(addr_out),   32'(e.a));
    chk({tag, "_data"},  32'(data_out),   32'(e.d));
    chk({tag, "_valid"}, 32'(data_valid), 32'd1);
  endtask

  task automatic press(input logic w, input logic r, input bit latency_chk);
    @(negedge clk);
    wr_btn = w;
    rd_btn = r;
    repeat (3) @(negedge clk);
    if (latency_chk) chk("latency_3cyc_valid", 32'(data_valid), 32'd0);
    @(negedge clk);
  endtask

  task automatic release_btns();
    wr_btn = 1'b0;
    rd_btn = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic mwrite(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit latency_chk);
    addr_in = a;
    data_in = d;
    model_ram[a] = d;
    exp_q.push_back('{a: a, d: d});
    press(1'b1, 1'b0, latency_chk);
    pop_check("wr");
    release_btns();
  endtask

  task automatic mread(input logic [AW-1:0] a);
    addr_in = a;
    exp_q.push_back('{a: a, d: model_ram[a]});
    press(1'b0, 1'b1, 1'b0);
    pop_check("rd");
    release_btns();
  endtask

  // Wait (bounded) for busy to rise after a wr rise in FILL mode.
  task automatic start_fill(input logic [DW-1:0] seed);
    int n;
    mode    = 2'b10;
    data_in = seed;
    @(negedge clk);
    wr_btn = 1'b1;
    n = 0;
    while (!busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("fill_busy_rise", 32'(busy), 32'd1);
    wr_btn = 1'b0;
  endtask

  task automatic do_fill(input logic [DW-1:0] seed, input bit rd_during);
    int            cyc;
    logic [DW-1:0] held;
    held = data_out;
    for (int unsigned i = 0; i < DEPTH; i++) model_ram[i] = seed + DW'(i);
    exp_q.push_back('{a: AW'(DEPTH - 1), d: seed + DW'(DEPTH - 1)});
    start_fill(seed);
    cyc = 0;
    while (busy && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (rd_during && cyc == 2)  rd_btn = 1'b1;
      if (rd_during && cyc == 10) begin
        rd_btn = 1'b0;
        chk("fill_data_held", 32'(data_out), 32'(held));
      end
    end
    chk("fill_busy_cycles", 32'(cyc), 32'(DEPTH));
    pop_check("fill_done");
    mode = 2'b00;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [AW-1:0] prev;
    int            n;

    rst = 1'b1; mode = 2'b00; addr_in = '0; data_in = '0;
    wr_btn = 1'b0; rd_btn = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_addr",  32'(addr_out),   32'd0);
    chk("rst_data",  32'(data_out),   32'd0);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_busy",  32'(busy),       32'd0);

    // MANUAL write-through then read back
    mwrite(4'h3, 8'hA5, 1'b1);
    mread(4'h3);

    // Simultaneous write and read: write wins
    addr_in = 4'h5;
    data_in = 8'h11;
    model_ram[5] = 8'h11;
    exp_q.push_back('{a: 4'h5, d: 8'h11});
    press(1'b1, 1'b1, 1'b0);
    pop_check("wr_rd_same");
    release_btns();
    mread(4'h5);
    mwrite(4'hC, 8'h3C, 1'b0);
    mread(4'h3);

    // FILL with carry wrap, rd pulses while busy ignored
    do_fill(8'hFE, 1'b1);
    mread(4'h0);
    mread(4'h1);
    mread(4'h2);
    mread(4'hF);

    // SCAN over identity ramp, including wrap F -> 0
    do_fill(8'h00, 1'b0);
    mode = 2'b01;
    for (int unsigned s = 0; s < 18; s++) begin
      exp_q.push_back('{a: AW'(s), d: model_ram[s % DEPTH]});
      prev = addr_out;
      n = 0;
      while (addr_out == prev && n < 20) begin
        @(negedge clk);
        n++;
      end
      pop_check("scan");
      if (s >= 1) chk("scan_interval", 32'(n), 32'd4);
    end
    mode = 2'b00;
    repeat (4) @(negedge clk);

    // Reset in the middle of a FILL, after words 0..5 are written
    start_fill(8'h40);
    repeat (6) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midfill_rst_addr",  32'(addr_out),   32'd0);
    chk("midfill_rst_data",  32'(data_out),   32'd0);
    chk("midfill_rst_valid", 32'(data_valid), 32'd0);
    chk("midfill_rst_busy",  32'(busy),       32'd0);
    for (int unsigned i = 0; i < 6; i++) model_ram[i] = 8'h40 + DW'(i);
    @(negedge clk);
    rst  = 1'b0;
    mode = 2'b00;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    for (int unsigned i = 0; i < DEPTH; i++) mread(AW'(i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
